// File: rtl/ones_accum.sv
// ones_accum: accumulates per-byte popcounts from an upstream ones-counter
// into frame totals. A frame ends on in_last or when MAX_LEN samples have
// been taken. The result is held until the downstream consumer accepts it.
module ones_accum #(
  parameter int MAX_LEN = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [3:0]  z,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_sum,
  output logic [7:0]  out_len,
  output logic        out_err,
  output logic        out_trunc
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        closing;
  logic        hit_max;
  logic [7:0]  len_nxt;

  logic [11:0] sum;
  logic [7:0]  len;
  logic        err;
  logic        trunc;

  // A popcount of a byte can never exceed 8; larger codes are flagged as
  // errors and contribute nothing to the sum.
  function automatic logic z_bad(input logic [3:0] v);
    return (v > 4'd8);
  endfunction

  function automatic logic [11:0] z_eff(input logic [3:0] v);
    return z_bad(v) ? 12'd0 : {8'd0, v};
  endfunction

  // State register; reset abandons any partial or pending frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; out_valid depends only on state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    len_nxt   = (state == ACC) ? (len + 8'd1) : 8'd1;
    hit_max   = (len_nxt == MAX_LEN_B);
    closing   = in_last || hit_max;
    case (state)
      IDLE, ACC: begin
        in_ready = ~reset;
        accept   = in_valid && ~reset;
        if (accept) begin
          state_nxt = closing ? DONE : ACC;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Frame accumulators; the first sample of a frame reloads them, and they
  // keep the last result after DONE until the next frame starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum   <= 12'd0;
      len   <= 8'd0;
      err   <= 1'b0;
      trunc <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        sum <= z_eff(z);
        err <= z_bad(z);
      end else begin
        sum <= sum + z_eff(z);
        err <= err | z_bad(z);
      end
      len   <= len_nxt;
      trunc <= hit_max && !in_last;
    end
  end

  assign out_sum   = sum;
  assign out_len   = len;
  assign out_err   = err;
  assign out_trunc = trunc;

endmodule

// File: tb/tb_ones_accum.sv
// tb_ones_accum: directed frames with literal expectations, then randomized
// traffic, all compared every cycle against a frame-level reference model.
module tb_ones_accum;

  localparam int MAX_LEN = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  z;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic [7:0]  out_len;
  logic        out_err;
  logic        out_trunc;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_acc = 0;

  always #5 clk = ~clk;

  ones_accum #(.MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .z         (z),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_len   (out_len),
    .out_err   (out_err),
    .out_trunc (out_trunc)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Reference model: a frame is a list of samples; a result is published
  // when the frame closes and consumed by one out_ready cycle.
  bit m_done = 0;
  bit m_open = 0;
  int f_sum = 0, f_len = 0;
  bit f_err = 0;
  int e_sum = 0, e_len = 0;
  bit e_err = 0, e_trunc = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_done = 0; m_open = 0;
      f_sum = 0; f_len = 0; f_err = 0;
      e_sum = 0; e_len = 0; e_err = 0; e_trunc = 0;
    end else if (m_done) begin
      if (out_ready) m_done = 0;
    end else if (in_valid) begin
      if (!m_open) begin
        f_sum = 0; f_len = 0; f_err = 0; m_open = 1;
      end
      f_len++;
      if (z <= 8) f_sum += int'(z);
      else f_err = 1;
      if (in_last || f_len == MAX_LEN) begin
        e_sum = f_sum; e_len = f_len; e_err = f_err; e_trunc = !in_last;
        m_done = 1; m_open = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_len", out_len, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_out_trunc", out_trunc, 0);
    end else begin
      chk("in_ready", in_ready, !m_done);
      chk("out_valid", out_valid, m_done);
      chk("out_sum", out_sum, m_open ? f_sum : e_sum);
      chk("out_len", out_len, m_open ? f_len : e_len);
      chk("out_err", out_err, m_open ? f_err : e_err);
      chk("out_trunc", out_trunc, m_open ? 0 : e_trunc);
    end
  end

  // Called and returns just after a rising edge; holds the sample until taken.
  task automatic send(input logic [3:0] zv, input logic last);
    int t = 0;
    in_valid = 1'b1; z = zv; in_last = last;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    last_acc = cyc;
    in_valid = 1'b0;
    z = 4'($urandom_range(0, 15));
    in_last = 1'($urandom_range(0, 1));
  endtask

  // Returns on a falling edge with out_valid high (or after the bound).
  task automatic wait_valid(input string nm);
    int t = 0;
    @(negedge clk);
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk(nm, out_valid, 1);
  endtask

  task automatic resync();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int prev_acc;
    reset = 1'b1; in_valid = 1'b0; z = 4'd0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("after_rst_in_ready", in_ready, 1);
    chk("after_rst_out_valid", out_valid, 0);
    chk("after_rst_out_sum", out_sum, 0);
    resync();

    // Plain frame, consumer always ready.
    send(4'd3, 0); send(4'd8, 0); send(4'd0, 0); send(4'd5, 1);
    wait_valid("f1_valid");
    chk("f1_sum", out_sum, 16);
    chk("f1_len", out_len, 4);
    chk("f1_err", out_err, 0);
    chk("f1_trunc", out_trunc, 0);
    @(negedge clk);
    chk("f1_one_cycle", out_valid, 0);
    resync();

    // Truncation at MAX_LEN; the 17th sample must be refused.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(4'd1, 0);
    in_valid = 1'b1; z = 4'd1; in_last = 1'b0;
    @(negedge clk);
    chk("tr_valid", out_valid, 1);
    chk("tr_in_ready", in_ready, 0);
    chk("tr_sum", out_sum, 16);
    chk("tr_len", out_len, 16);
    chk("tr_trunc", out_trunc, 1);
    resync();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(4'd1, 0);
    reset = 1'b1;
    resync();
    reset = 1'b0;

    // Back-pressure holds the result and blocks input.
    out_ready = 1'b0;
    send(4'd7, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", out_sum, 7);
      chk("bp_len", out_len, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    resync();
    out_ready = 1'b1;
    resync();

    // Out-of-range popcount flags the frame but adds nothing.
    send(4'd2, 0); send(4'd12, 0); send(4'd4, 1);
    wait_valid("er_valid");
    chk("er_sum", out_sum, 6);
    chk("er_len", out_len, 3);
    chk("er_err", out_err, 1);
    resync();
    send(4'd1, 1);
    wait_valid("er2_valid");
    chk("er2_err", out_err, 0);
    chk("er2_sum", out_sum, 1);
    resync();

    // Reset in the middle of a frame.
    send(4'd5, 0); send(4'd5, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_sum", out_sum, 0);
    chk("mr_len", out_len, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_in_ready", in_ready, 0);
    resync();
    reset = 1'b0;
    send(4'd4, 1);
    wait_valid("mr2_valid");
    chk("mr2_sum", out_sum, 4);
    chk("mr2_len", out_len, 1);
    resync();

    // Idle gaps inside a frame, then back-to-back single-sample frames.
    send(4'd8, 0);
    repeat (3) @(posedge clk);
    #1;
    send(4'd8, 1);
    wait_valid("gap_valid");
    chk("gap_sum", out_sum, 16);
    chk("gap_len", out_len, 2);
    resync();
    send(4'd1, 1);
    prev_acc = last_acc;
    send(4'd2, 1);
    chk("bubble_spacing", last_acc - prev_acc, 2);

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      z         = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      in_last   = ($urandom_range(0, 9) < 2);
      out_ready = ($urandom_range(0, 9) < 6);
      reset     = ($urandom_range(0, 399) == 0);
      resync();
    end
    reset = 1'b0; in_valid = 1'b0;
    repeat (3) resync();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ones_accum.md
ONES_ACCUM -- requirements
Module: ones_accum

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning maximum bytes per frame (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream popcount sample valid.
REQ-005 SHALL have port z  input  4  popcount of one 8-bit byte from the upstream ones-counter stage (legal 0..8).
REQ-006 SHALL have port in_last  input  1  marks final sample of a frame; qualified by in_valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a sample this cycle.
REQ-008 SHALL have port out_valid  output  1  frame result available.
REQ-009 SHALL have port out_ready  input  1  downstream accepts result.
REQ-010 SHALL have port out_sum  output  12  total ones in frame.
REQ-011 SHALL have port out_len  output  8  number of samples accepted in frame.
REQ-012 SHALL have port out_err  output  1  at least one sample had z > 8.
REQ-013 SHALL have port out_trunc  output  1  frame closed by reaching MAX_LEN without in_last.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, ACC, DONE.
REQ-015 SHALL drive in_ready = 1 in IDLE and ACC, 0 in DONE; out_valid = 1 only in DONE.
REQ-016 SHALL accept a sample on a rising edge where in_valid && in_ready; no other cycle changes sum/len.
REQ-017 SHALL, on accept in IDLE, load sum = zeff, len = 1, err = (z > 8), trunc = 0, where zeff = z if z <= 8 else 0.
REQ-018 SHALL, on accept in ACC, update sum += zeff, len += 1, err |= (z > 8).
REQ-019 SHALL transition IDLE->ACC on accept with in_last = 0 and MAX_LEN > 1.
REQ-020 SHALL transition to DONE from IDLE or ACC on the accepting edge when in_last = 1 or the new len equals MAX_LEN.
REQ-021 SHALL set trunc = 1 when closing on len == MAX_LEN with in_last = 0; in_last = 1 on that same sample gives trunc = 0.
REQ-022 SHALL remain in ACC with no change while in_valid = 0 (arbitrary gaps allowed).
REQ-023 SHALL hold out_sum, out_len, out_err, out_trunc stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL transition DONE->IDLE on the edge where out_valid && out_ready; result outputs keep last values until the next frame's first accept.
REQ-025 SHALL not accept in the DONE-exit cycle (in_ready = 0 then); earliest next accept is the following cycle (one-cycle bubble).
REQ-026 SHALL size sum at 12 bits without wrap (max 8*255 = 2040).
REQ-027 SHALL ignore in_last and z when in_valid = 0.
REQ-028 SHALL have out_valid independent of out_ready combinationally (registered state only).

Reset
REQ-029 SHALL, on reset asserted, immediately enter IDLE and drive in_ready = 1 (once reset deasserted), out_valid = 0, out_sum = 0, out_len = 0, out_err = 0, out_trunc = 0.
REQ-030 SHALL, with reset asserted, drive in_ready = 0 and accept nothing.
REQ-031 SHALL abandon any partial frame on reset mid-ACC or mid-DONE with no result emitted.

Verification
REQ-032 SHALL cover: frame z = 3,8,0,5 with in_last on 4th, out_ready = 1 -> out_valid one cycle, out_sum = 16, out_len = 4, err = 0, trunc = 0.
REQ-033 SHALL cover: 20 samples z = 1 with no in_last, MAX_LEN = 16 -> close after 16th, out_sum = 16, out_len = 16, trunc = 1; 17th sample sees in_ready = 0.
REQ-034 SHALL cover: single sample z = 7 with in_last from IDLE, out_ready held 0 for 5 cycles -> out_valid high 5+ cycles, out_sum = 7, out_len = 1 stable, in_ready = 0 throughout.
REQ-035 SHALL cover: frame z = 2,12,4 with in_last on 3rd -> out_sum = 6, out_len = 3, out_err = 1; next frame z = 1 last -> out_err = 0.
REQ-036 SHALL cover: reset pulsed after 2 accepted samples (z = 5,5) -> outputs zero, IDLE; subsequent frame z = 4 last -> out_sum = 4, out_len = 1.
REQ-037 SHALL cover: in_valid gaps of 3 idle cycles between samples z = 8,8 last -> out_sum = 16, out_len = 2; back-to-back frames show exactly one bubble cycle.
